// File: rtl/laser_fire_ctrl.sv
// Laser fire control: debounces the fire button, runs the burst/overheat FSM and meters the energy gauge.
// Everything advances once per frame_tick. Define LASER_SHOT_COUNT_EN to add the shot_count port.
module laser_fire_ctrl #(
  parameter int ENERGY_MAX      = 255,
  parameter int DRAIN           = 4,
  parameter int RECHARGE        = 2,
  parameter int MIN_FIRE_ENERGY = 32,
  parameter int RESUME_LEVEL    = 128,
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int MIN_BURST       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fire_btn,
  input  logic        frame_tick,
  output logic        shooting,
  output logic [7:0]  energy,
  output logic        overheat,
  output logic        ready
`ifdef LASER_SHOT_COUNT_EN
  ,
  output logic [15:0] shot_count
`endif
);
  localparam logic [8:0] EMAX9  = 9'(ENERGY_MAX);
  localparam logic [8:0] RECH9  = 9'(RECHARGE);
  localparam logic [7:0] DRAIN8 = 8'(DRAIN);
  localparam logic [7:0] MINF8  = 8'(MIN_FIRE_ENERGY);
  localparam logic [7:0] RES8   = 8'(RESUME_LEVEL);
  localparam logic [2:0] DEB3   = 3'(DEBOUNCE_FRAMES);
  localparam logic [3:0] MINB4  = 4'(MIN_BURST);

  typedef enum logic [1:0] {IDLE = 2'd0, FIRING = 2'd1, COOLDOWN = 2'd2} state_t;

  state_t     state_q, state_d;
  logic [1:0] sync_q;
  logic       fire_db_q, fire_db_d;
  logic [2:0] dcnt_q, dcnt_d;
  logic [3:0] burst_q, burst_d;
  logic [7:0] energy_q, energy_d;
  logic       shooting_q, overheat_q, ready_q;
  logic [8:0] sum9;
  logic [7:0] recharged, drained;

  // Recharge in 9 bits so the clamp sees the true sum; drain floors at zero.
  assign sum9      = {1'b0, energy_q} + RECH9;
  assign recharged = (sum9 > EMAX9) ? EMAX9[7:0] : sum9[7:0];
  assign drained   = (energy_q > DRAIN8) ? energy_q - DRAIN8 : 8'd0;

  always_comb begin
    fire_db_d = fire_db_q;
    dcnt_d    = dcnt_q;
    if (frame_tick) begin
      if (sync_q[1] == fire_db_q) begin
        dcnt_d = '0;
      end else if (dcnt_q + 3'd1 == DEB3) begin
        fire_db_d = sync_q[1];
        dcnt_d    = '0;
      end else begin
        dcnt_d = dcnt_q + 3'd1;
      end
    end
  end

  // The FSM sees fire_db_q, i.e. the debounced level from before this tick.
  always_comb begin
    state_d  = state_q;
    energy_d = energy_q;
    burst_d  = burst_q;
    if (frame_tick) begin
      case (state_q)
        IDLE: begin
          if (fire_db_q && energy_q >= MINF8) begin
            state_d = FIRING;
            burst_d = '0;
          end else begin
            energy_d = recharged;
          end
        end
        FIRING: begin
          if (!fire_db_q && burst_q >= MINB4) begin
            state_d = IDLE;
          end else begin
            energy_d = drained;
            if (burst_q != 4'hF) burst_d = burst_q + 4'd1;
            if (drained == 8'd0) state_d = COOLDOWN;
          end
        end
        COOLDOWN: begin
          energy_d = recharged;
          if (recharged >= RES8) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      fire_db_q  <= 1'b0;
      dcnt_q     <= '0;
      burst_q    <= '0;
      state_q    <= IDLE;
      energy_q   <= EMAX9[7:0];
      shooting_q <= 1'b0;
      overheat_q <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      sync_q     <= {sync_q[0], fire_btn};
      fire_db_q  <= fire_db_d;
      dcnt_q     <= dcnt_d;
      burst_q    <= burst_d;
      state_q    <= state_d;
      energy_q   <= energy_d;
      shooting_q <= (state_d == FIRING);
      overheat_q <= (state_d == COOLDOWN);
      ready_q    <= (state_d == IDLE) && (energy_d >= MINF8);
    end
  end

  assign shooting = shooting_q;
  assign overheat = overheat_q;
  assign ready    = ready_q;
  assign energy   = energy_q;

`ifdef LASER_SHOT_COUNT_EN
  logic [15:0] shots_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shots_q <= '0;
    end else if (state_q == IDLE && state_d == FIRING && shots_q != 16'hFFFF) begin
      shots_q <= shots_q + 16'd1;
    end
  end

  assign shot_count = shots_q;
`endif

endmodule

// File: tb/tb_laser_fire_ctrl.sv
// Bench for laser_fire_ctrl: frame-level behavioural model compared every cycle, plus directed literal checks.
module tb_laser_fire_ctrl;
  localparam int EMAX = 255, DRN = 4, RCH = 2, MINF = 32, RES = 128, DEB = 2, MINB = 8;
  localparam int M_IDLE = 0, M_FIRE = 1, M_COOL = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fire_btn = 1'b0;
  logic        frame_tick = 1'b0;
  logic        shooting, overheat, ready;
  logic [7:0]  energy;
`ifdef LASER_SHOT_COUNT_EN
  logic [15:0] shot_count;
`endif

  int checks = 0;
  int errors = 0;

  laser_fire_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .fire_btn   (fire_btn),
    .frame_tick (frame_tick),
    .shooting   (shooting),
    .energy     (energy),
    .overheat   (overheat),
    .ready      (ready)
`ifdef LASER_SHOT_COUNT_EN
    ,
    .shot_count (shot_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: button seen two clocks late, debounced run-length, gauge in plain integers.
  bit m_init = 1'b0;
  bit m_s1, m_s2, m_db, db_prev;
  int m_run, m_state, m_e, m_burst, m_shots;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_init = 1'b1; m_s1 = 0; m_s2 = 0; m_db = 0; m_run = 0;
        m_state = M_IDLE; m_e = EMAX; m_burst = 0; m_shots = 0;
      end else begin
        if (frame_tick) begin
          db_prev = m_db;
          if (m_s2 == m_db) m_run = 0;
          else begin
            m_run++;
            if (m_run == DEB) begin m_db = m_s2; m_run = 0; end
          end
          case (m_state)
            M_IDLE:
              if (db_prev && m_e >= MINF) begin
                m_state = M_FIRE; m_burst = 0;
                if (m_shots < 65535) m_shots++;
              end else m_e = (m_e + RCH > EMAX) ? EMAX : m_e + RCH;
            M_FIRE:
              if (!db_prev && m_burst >= MINB) m_state = M_IDLE;
              else begin
                m_e = (m_e > DRN) ? m_e - DRN : 0;
                m_burst++;
                if (m_e == 0) m_state = M_COOL;
              end
            default: begin
              m_e = (m_e + RCH > EMAX) ? EMAX : m_e + RCH;
              if (m_e >= RES) m_state = M_IDLE;
            end
          endcase
        end
        m_s2 = m_s1;
        m_s1 = fire_btn;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init && !reset) begin
      check("model.shooting", shooting, int'(m_state == M_FIRE));
      check("model.overheat", overheat, int'(m_state == M_COOL));
      check("model.energy", energy, m_e);
      check("model.ready", ready, int'(m_state == M_IDLE && m_e >= MINF));
`ifdef LASER_SHOT_COUNT_EN
      check("model.shot_count", shot_count, m_shots);
`endif
    end
  end

  task automatic tick();
    repeat (3) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset values
    do_reset();
    check("rst.energy", energy, 255);
    check("rst.shooting", shooting, 0);
    check("rst.overheat", overheat, 0);
    check("rst.ready", ready, 1);

    // Held button: two debounce ticks, fire on the third, drain from the fourth
    fire_btn = 1'b1;
    tick(); check("t1.shooting", shooting, 0);
    tick(); check("t2.shooting", shooting, 0);
    tick(); check("t3.shooting", shooting, 1); check("t3.energy", energy, 255);
    tick(); check("t4.energy", energy, 251);

    // Release: burst runs to its 8-frame minimum, then recharges
    fire_btn = 1'b0;
    repeat (7) tick();
    check("burst.last_energy", energy, 223);
    check("burst.last_shooting", shooting, 1);
    tick();
    check("burst.exit_shooting", shooting, 0);
    check("burst.exit_energy", energy, 223);
    check("burst.exit_ready", ready, 1);
    tick(); check("recharge.energy", energy, 225);

    // One-frame glitch never reaches the debounced level
    do_reset();
    fire_btn = 1'b1; tick();
    fire_btn = 1'b0;
    repeat (3) tick();
    check("glitch.shooting", shooting, 0);
    check("glitch.energy", energy, 255);

    // Continuous hold: drain to empty, cooldown to 128, fire again
    fire_btn = 1'b1;
    repeat (3) tick();
    check("hold.fire", shooting, 1);
    repeat (63) tick();
    check("hold.energy3", energy, 3);
    tick();
    check("hold.empty_energy", energy, 0);
    check("hold.empty_shooting", shooting, 0);
    check("hold.overheat", overheat, 1);
    check("hold.ready", ready, 0);
    repeat (63) tick();
    check("cool.energy126", energy, 126);
    check("cool.overheat", overheat, 1);
    tick();
    check("cool.exit_energy", energy, 128);
    check("cool.exit_overheat", overheat, 0);
    check("cool.exit_ready", ready, 1);
    check("cool.exit_shooting", shooting, 0);
    tick();
    check("refire.shooting", shooting, 1);
    check("refire.energy", energy, 128);

    // Drain to 28, release just long enough to exit, re-press while the gauge is below threshold
    repeat (23) tick();
    fire_btn = 1'b0;
    tick();
    tick(); check("low.drain_energy", energy, 28);
    fire_btn = 1'b1;
    tick();
    check("low.exit_shooting", shooting, 0);
    check("low.exit_energy", energy, 28);
    tick();
    check("low.energy30", energy, 30);
    check("low.ready30", ready, 0);
    tick();
    check("low.nofire", shooting, 0);
    check("low.energy32", energy, 32);
    tick();
    check("low.fire32", shooting, 1);
    tick();
    check("low.drain28", energy, 28);

    // Asynchronous reset mid-burst
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst.shooting", shooting, 0);
    check("midrst.energy", energy, 255);
    check("midrst.overheat", overheat, 0);
    check("midrst.ready", ready, 1);
`ifdef LASER_SHOT_COUNT_EN
    check("midrst.shot_count", shot_count, 0);
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    fire_btn = 1'b1;
    repeat (3) tick();
    check("post.shooting", shooting, 1);
`ifdef LASER_SHOT_COUNT_EN
    check("post.shot_count", shot_count, 1);
`endif

    fire_btn = 1'b0;
    repeat (12) tick();
    check("end.shooting", shooting, 0);
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
